hazard_tracker: RTL
===================

Name: hazard_tracker

Overview:
- Pipeline hazard bookkeeping for the 5-stage MIPS core. Sits directly downstream of the D-stage instruction decoder and consumes its Tuse_rs/Tuse_rt/Tnew/A3 outputs.
- Keeps a per-stage (E, M, W) record of pending register writes and counts Tnew down as instructions advance.
- Produces the D-stage stall request and the forwarding-mux selects for the D and E stages.

Parameters:
- REG_AW, 5, register-address width
- TW, 2, width of Tuse/Tnew fields

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all stage records
- d_valid  in  1  D stage holds a real instruction
- d_rs  in  REG_AW  rs field of the D-stage instruction
- d_rt  in  REG_AW  rt field of the D-stage instruction
- d_tuse_rs  in  TW  cycles until D instruction needs rs (3 = never)
- d_tuse_rt  in  TW  cycles until D instruction needs rt (3 = never)
- d_tnew  in  TW  Tnew the instruction carries into E
- d_a3  in  REG_AW  destination register (0 = no write)
- stall  out  1  freeze PC and F/D register; insert bubble into E
- fwd_d_rs  out  2  D-stage rs forward select
- fwd_d_rt  out  2  D-stage rt forward select
- fwd_e_rs  out  2  E-stage rs forward select
- fwd_e_rt  out  2  E-stage rt forward select

Behaviour:
- State: three stage records E, M, W. Each holds a3[REG_AW] and tnew[TW]; E also holds rs and rt.
- Reset: all records become {a3=0, tnew=0, rs=0, rt=0}. The reset takes effect on the clock edge; the pipeline is empty on the next cycle.
- Outputs are combinational from the records and the D inputs. With cleared records, stall=0 and all fwd selects are 0. Reset mid-operation drops every in-flight record.
- Per-edge update, normal case (stall=0):
  - E <= {d_a3, d_tnew, d_rs, d_rt} when d_valid; otherwise E <= bubble (all zero).
  - M <= E with tnew = sat_dec(E.tnew).
  - W <= M with tnew = sat_dec(M.tnew).
- Per-edge update, stall=1: E <= bubble. M and W advance exactly as in the normal case.
- sat_dec(x) = (x==0) ? 0 : x-1.
- match(S, r) = (S.a3 != 0) && (S.a3 == r).
- Stall:
  - stall = d_valid && (hz(d_rs, d_tuse_rs) || hz(d_rt, d_tuse_rt)).
  - hz(r, tu) = (match(E,r) && tu < E.tnew) || (match(M,r) && tu < M.tnew).
  - W tnew is always 0 and never causes a stall.
- D-stage forward select (for fwd_d_rs and fwd_d_rt), first true wins:
  - 3 if match(E,r) && E.tnew==0
  - 2 if match(M,r) && M.tnew==0
  - 1 if match(W,r)
  - 0 otherwise
- E-stage forward select (for fwd_e_rs and fwd_e_rt, r = E.rs or E.rt), first true wins:
  - 2 if match(M,r) && M.tnew==0
  - 1 if match(W,r)
  - 0 otherwise
- Nearest stage has priority. A younger pending write masks an older ready write: if match(E,r) with E.tnew>0, the D select is 0 (no fall-through to M/W). The same masking applies to M for the E select.
- Register $0 is never forwarded and never stalls.
- Simultaneous events: a stall and a W-stage retire in the same cycle are independent. The bubble enters E, and M and W still advance.
- Latency: zero-cycle combinational decision; one-cycle record update.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined: add output stall_cnt [31:0]. It increments on each cycle with stall=1, saturates at 32'hFFFF_FFFF, and clears on reset.
- When undefined: the port and counter are absent. Core behaviour is identical in both builds.

Decomposition:
- Shared package/header hazard_defs: FWD_NONE=0, FWD_W=1, FWD_M=2, FWD_E=3, TUSE_NEVER=3, stage-record field widths. The decoder and the datapath forwarding muxes include it too.
- One natural sub-module: hazard_stage_reg, a single stage record with advance/bubble/reset controls and saturating tnew decrement. It is instantiated three times.

Test Plan:
- lw $1 (Tnew=2) followed by addu $2,$1,$1 (Tuse_rs=1): stall=1 for exactly 1 cycle. Afterwards fwd_e_rs=1 (from W) once lw reaches W.
- addu $3 (Tnew=1) followed by beq $3,$0 (Tuse=0): stall=1 for 1 cycle, then fwd_d_rs=2 (from M).
- jal (a3=31, Tnew=0) followed by jr $31 (Tuse=0): stall=0, fwd_d_rs=3.
- Write to $0 in E with Tnew=2, then D reads $0 with Tuse=0: stall=0, fwd=0.
- E and W both target $5 (E Tnew=1), D reads $5 with Tuse=1: fwd_d=0, stall=0. Next cycle fwd_e=2.
- Assert reset while lw is in E and a dependent is in D: stall=0 and all fwd=0 on the next cycle. With HAZARD_STATS_EN, stall_cnt=0.

Source files
------------

// File: rtl/hazard_tracker_pkg.sv
// Shared hazard definitions: forward-select codes, stage-record layout and the
// match/stall/select rules used by the tracker, the decoder and the datapath muxes.
package hazard_tracker_pkg;

   localparam int REG_AW = 5;
   localparam int TW     = 2;

   localparam logic [1:0] FWD_NONE = 2'd0;
   localparam logic [1:0] FWD_W    = 2'd1;
   localparam logic [1:0] FWD_M    = 2'd2;
   localparam logic [1:0] FWD_E    = 2'd3;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [TW-1:0]     tcnt_t;

   localparam tcnt_t TUSE_NEVER = tcnt_t'(3);

   typedef struct packed {
      reg_addr_t a3;
      tcnt_t     tnew;
   } stage_rec_t;

   function automatic tcnt_t sat_dec(tcnt_t x);
      tcnt_t y;
      y = (x == '0) ? '0 : x - 1'b1;
      return y;
   endfunction

   // $0 is hard-wired, so a record writing it never matches anything.
   function automatic logic rec_match(stage_rec_t s, reg_addr_t r);
      return (s.a3 != '0) && (s.a3 == r);
   endfunction

   function automatic logic hz(stage_rec_t e, stage_rec_t m, reg_addr_t r, tcnt_t tu);
      return (rec_match(e, r) && (tu < e.tnew)) || (rec_match(m, r) && (tu < m.tnew));
   endfunction

   // Nearest matching stage decides; a not-yet-ready younger write yields FWD_NONE
   // rather than letting an older, stale value through.
   function automatic logic [1:0] fwd_d_sel(stage_rec_t e, stage_rec_t m, stage_rec_t w,
                                            reg_addr_t r);
      logic [1:0] sel;
      sel = FWD_NONE;
      if (rec_match(e, r))      sel = (e.tnew == '0) ? FWD_E : FWD_NONE;
      else if (rec_match(m, r)) sel = (m.tnew == '0) ? FWD_M : FWD_NONE;
      else if (rec_match(w, r)) sel = FWD_W;
      return sel;
   endfunction

   function automatic logic [1:0] fwd_e_sel(stage_rec_t m, stage_rec_t w, reg_addr_t r);
      logic [1:0] sel;
      sel = FWD_NONE;
      if (rec_match(m, r))      sel = (m.tnew == '0) ? FWD_M : FWD_NONE;
      else if (rec_match(w, r)) sel = FWD_W;
      return sel;
   endfunction

endpackage

// File: rtl/hazard_tracker_if.sv
// D-stage decode fields in, stall and forward selects out.
// master = decoder/pipeline side, slave = hazard tracker.
interface hazard_tracker_if;
   import hazard_tracker_pkg::*;

   logic       d_valid;
   reg_addr_t  d_rs;
   reg_addr_t  d_rt;
   tcnt_t      d_tuse_rs;
   tcnt_t      d_tuse_rt;
   tcnt_t      d_tnew;
   reg_addr_t  d_a3;
   logic       stall;
   logic [1:0] fwd_d_rs;
   logic [1:0] fwd_d_rt;
   logic [1:0] fwd_e_rs;
   logic [1:0] fwd_e_rt;

   modport master (
      output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_tnew, d_a3,
      input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt
   );

   modport slave (
      input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_tnew, d_a3,
      output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt
   );

endinterface

// File: rtl/hazard_tracker_stage_reg.sv
// One pipeline-stage write record (a3, tnew); loads every edge, optionally
// decrementing tnew with saturation, or loads an all-zero bubble.
module hazard_stage_reg
   import hazard_tracker_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       bubble_i,
   input  logic       dec_i,
   input  stage_rec_t rec_i,
   output stage_rec_t rec_o
);

   stage_rec_t rec_d;
   stage_rec_t rec_q;

   always_comb begin
      rec_d = rec_i;
      if (dec_i) rec_d.tnew = sat_dec(rec_i.tnew);
      if (bubble_i) rec_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) rec_q <= '0;
      else       rec_q <= rec_d;
   end

   assign rec_o = rec_q;

endmodule

// File: rtl/hazard_tracker.sv
// E/M/W pending-write bookkeeping: combinational D-stage stall and D/E forward
// selects, one-cycle record update. HAZARD_STATS_EN adds a saturating stall counter.
module hazard_tracker
   import hazard_tracker_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   hazard_tracker_if.slave hz_if
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]  stall_cnt
`endif
);

   stage_rec_t e_rec, m_rec, w_rec;
   stage_rec_t d_rec;
   reg_addr_t  e_rs_q, e_rs_d;
   reg_addr_t  e_rt_q, e_rt_d;
   logic       stall;
   logic       e_bubble;
   logic       unused_w_tnew;

   assign d_rec    = '{a3: hz_if.d_a3, tnew: hz_if.d_tnew};
   assign stall    = hz_if.d_valid && (hz(e_rec, m_rec, hz_if.d_rs, hz_if.d_tuse_rs) ||
                                       hz(e_rec, m_rec, hz_if.d_rt, hz_if.d_tuse_rt));
   assign e_bubble = stall || !hz_if.d_valid;

   hazard_stage_reg u_e (
      .clk(clk), .reset(reset), .bubble_i(e_bubble), .dec_i(1'b0), .rec_i(d_rec), .rec_o(e_rec)
   );
   hazard_stage_reg u_m (
      .clk(clk), .reset(reset), .bubble_i(1'b0), .dec_i(1'b1), .rec_i(e_rec), .rec_o(m_rec)
   );
   hazard_stage_reg u_w (
      .clk(clk), .reset(reset), .bubble_i(1'b0), .dec_i(1'b1), .rec_i(m_rec), .rec_o(w_rec)
   );

   // Source operands of the E instruction, needed for the E-stage selects.
   always_comb begin
      e_rs_d = e_bubble ? '0 : hz_if.d_rs;
      e_rt_d = e_bubble ? '0 : hz_if.d_rt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_rs_q <= '0;
         e_rt_q <= '0;
      end else begin
         e_rs_q <= e_rs_d;
         e_rt_q <= e_rt_d;
      end
   end

   // A W-stage record is always ready, so its tnew never feeds a decision.
   assign unused_w_tnew = ^w_rec.tnew;

   assign hz_if.stall    = stall;
   assign hz_if.fwd_d_rs = fwd_d_sel(e_rec, m_rec, w_rec, hz_if.d_rs);
   assign hz_if.fwd_d_rt = fwd_d_sel(e_rec, m_rec, w_rec, hz_if.d_rt);
   assign hz_if.fwd_e_rs = fwd_e_sel(m_rec, w_rec, e_rs_q);
   assign hz_if.fwd_e_rt = fwd_e_sel(m_rec, w_rec, e_rt_q);

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
